// File: rtl/hdmi_pkg.sv
// Shared HDMI period definitions: TMDS mode codes, preamble patterns
// and period lengths used by the scheduler, encoders and assembler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    MODE_CONTROL      = 3'd0,
    MODE_VIDEO        = 3'd1,
    MODE_VIDEO_GUARD  = 3'd2,
    MODE_ISLAND_DATA  = 3'd3,
    MODE_ISLAND_GUARD = 3'd4
  } mode_t;

  typedef enum logic [2:0] {
    S_CTRL,
    S_VID_PRE,
    S_VID_GB,
    S_VIDEO,
    S_DI_PRE,
    S_DI_LGB,
    S_DI_DATA,
    S_DI_TGB
  } period_t;

  localparam logic [3:0] PREAMBLE_VIDEO  = 4'b0001;
  localparam logic [3:0] PREAMBLE_ISLAND = 4'b0101;

  localparam int PREAMBLE_LEN    = 8;
  localparam int GUARD_LEN       = 2;
  localparam int PACKET_LEN      = 32;
  localparam int MIN_CTRL_PERIOD = 12;

  // Lead needed before video to fit preamble and leading guard band.
  localparam int VIDEO_LEAD = PREAMBLE_LEN + GUARD_LEN;

  // Lead needed to start an island and still leave a full control period.
  localparam int ISLAND_LEAD =
    PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN + MIN_CTRL_PERIOD;

  // Lead at the last data pixel needed to append one more packet.
  localparam int NEXT_PKT_LEAD =
    PACKET_LEN + GUARD_LEN + MIN_CTRL_PERIOD + 1;

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: picks control, video or data-island
// periods and drives the TMDS mode bus and CTL preamble bits.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int MAX_PACKETS  = 18,
  parameter int MIN_CTRL_RUN = 4,
  parameter int CTV_WIDTH    = 12,
  parameter bit DVI_OUTPUT   = 1'b0
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 de,
  input  logic [CTV_WIDTH-1:0] cycles_to_video,
  input  logic                 packet_valid,
  output logic [2:0]           mode,
  output logic [3:0]           ctl,
  output logic                 packet_start,
  output logic [4:0]           pixel_index,
  output logic                 sched_error
);

  localparam int RUN_W = $clog2(MIN_CTRL_RUN + 1);

  localparam logic [CTV_WIDTH-1:0] VID_LEAD =
    CTV_WIDTH'(VIDEO_LEAD);
  localparam logic [CTV_WIDTH-1:0] ISL_LEAD =
    CTV_WIDTH'(ISLAND_LEAD);
  localparam logic [CTV_WIDTH-1:0] PKT_LEAD =
    CTV_WIDTH'(NEXT_PKT_LEAD);

  localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(MIN_CTRL_RUN);
  localparam logic [4:0] PKT_MAX  = 5'(MAX_PACKETS);
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] GB_LAST  = 5'(GUARD_LEN - 1);
  localparam logic [4:0] PKT_LAST = 5'(PACKET_LEN - 1);

  period_t          st;
  period_t          st_n;
  period_t          cur;
  logic [4:0]       phase;
  logic [4:0]       phase_n;
  logic [4:0]       pkt_cnt;
  logic [4:0]       pkt_cnt_n;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_n;
  logic             err_n;
  mode_t            mode_d;
  logic [3:0]       ctl_d;
  logic             ps_d;
  logic [4:0]       pix_d;

  // Decide the period of the pixel sampled this cycle.
  always_comb begin
    cur   = st;
    err_n = sched_error;
    if (DVI_OUTPUT) begin
      cur = de ? S_VIDEO : S_CTRL;
    end else begin
      if (st == S_VIDEO && !de)
        cur = S_CTRL;
      if (de && st != S_VIDEO) begin
        cur   = S_VIDEO;
        err_n = 1'b1;
      end else if (cur == S_CTRL) begin
        if (cycles_to_video == VID_LEAD)
          cur = S_VID_PRE;
        else if (packet_valid && run >= RUN_MIN &&
                 cycles_to_video >= ISL_LEAD)
          cur = S_DI_PRE;
      end
    end
  end

  // Advance phase/packet/run counters and build the pixel's outputs.
  always_comb begin
    st_n      = cur;
    phase_n   = 5'd0;
    pkt_cnt_n = pkt_cnt;
    run_n     = '0;
    mode_d    = MODE_CONTROL;
    ctl_d     = 4'b0000;
    ps_d      = 1'b0;
    pix_d     = 5'd0;
    unique case (cur)
      S_CTRL: begin
        run_n = (run >= RUN_MIN) ? run : run + RUN_W'(1);
      end
      S_VIDEO: begin
        mode_d = MODE_VIDEO;
      end
      S_VID_PRE: begin
        ctl_d = PREAMBLE_VIDEO;
        if (phase == PRE_LAST) st_n = S_VID_GB;
        else phase_n = phase + 5'd1;
      end
      S_VID_GB: begin
        mode_d = MODE_VIDEO_GUARD;
        if (phase == GB_LAST) st_n = S_VIDEO;
        else phase_n = phase + 5'd1;
      end
      S_DI_PRE: begin
        ctl_d     = PREAMBLE_ISLAND;
        pkt_cnt_n = 5'd0;
        if (phase == PRE_LAST) st_n = S_DI_LGB;
        else phase_n = phase + 5'd1;
      end
      S_DI_LGB: begin
        mode_d = MODE_ISLAND_GUARD;
        if (phase == GB_LAST) st_n = S_DI_DATA;
        else phase_n = phase + 5'd1;
      end
      S_DI_DATA: begin
        mode_d = MODE_ISLAND_DATA;
        pix_d  = phase;
        ps_d   = (phase == 5'd0);
        if (phase == 5'd0)
          pkt_cnt_n = pkt_cnt + 5'd1;
        if (phase == PKT_LAST) begin
          if (packet_valid && pkt_cnt < PKT_MAX &&
              cycles_to_video >= PKT_LEAD)
            st_n = S_DI_DATA;
          else
            st_n = S_DI_TGB;
        end else begin
          phase_n = phase + 5'd1;
        end
      end
      S_DI_TGB: begin
        mode_d = MODE_ISLAND_GUARD;
        if (phase == GB_LAST) st_n = S_CTRL;
        else phase_n = phase + 5'd1;
      end
      default: ;
    endcase
  end

  // Scheduler state and registered outputs, one pixel behind inputs.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      st           <= S_CTRL;
      phase        <= 5'd0;
      pkt_cnt      <= 5'd0;
      run          <= '0;
      mode         <= 3'd0;
      ctl          <= 4'b0000;
      packet_start <= 1'b0;
      pixel_index  <= 5'd0;
      sched_error  <= 1'b0;
    end else begin
      st           <= st_n;
      phase        <= phase_n;
      pkt_cnt      <= pkt_cnt_n;
      run          <= run_n;
      mode         <= mode_d;
      ctl          <= ctl_d;
      packet_start <= ps_d;
      pixel_index  <= pix_d;
      sched_error  <= err_n;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: queue-based period model plus
// directed scenarios with hand-counted period lengths.
module tb_hdmi_period_scheduler;

  localparam int MAXP    = 18;
  localparam int MINRUN  = 4;
  localparam int LEAD_V  = 8 + 2;
  localparam int LEAD_I  = 8 + 2 + 32 + 2 + 12;
  localparam int LEAD_P  = 32 + 2 + 12 + 1;
  localparam int SAT     = 4095;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic        de        = 1'b0;
  logic [11:0] ctv       = 12'd0;
  logic        pv        = 1'b0;

  logic [2:0] mode, d_mode;
  logic [3:0] ctl, d_ctl;
  logic       ps, d_ps, err, d_err;
  logic [4:0] idx, d_idx;

  hdmi_period_scheduler #(
    .MAX_PACKETS(MAXP), .MIN_CTRL_RUN(MINRUN),
    .CTV_WIDTH(12), .DVI_OUTPUT(1'b0)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .de(de),
    .cycles_to_video(ctv), .packet_valid(pv),
    .mode(mode), .ctl(ctl), .packet_start(ps),
    .pixel_index(idx), .sched_error(err)
  );

  hdmi_period_scheduler #(
    .MAX_PACKETS(MAXP), .MIN_CTRL_RUN(MINRUN),
    .CTV_WIDTH(12), .DVI_OUTPUT(1'b1)
  ) dut_dvi (
    .clk_pixel(clk_pixel), .reset(reset), .de(de),
    .cycles_to_video(ctv), .packet_valid(pv),
    .mode(d_mode), .ctl(d_ctl), .packet_start(d_ps),
    .pixel_index(d_idx), .sched_error(d_err)
  );

  always #5 clk_pixel = ~clk_pixel;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] ctl;
    logic       ps;
    logic [4:0] idx;
    logic       last;
    logic       vid_end;
    logic       isl_end;
  } ent_t;

  ent_t plan[$];
  int   m_run, m_pkts;
  bit   m_err, m_invid;
  int   e_mode, e_ctl, e_ps, e_idx;

  task automatic push_n(input int n, input logic [2:0] md,
                        input logic [3:0] c, input bit vend,
                        input bit iend);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.mode = md;
      e.ctl = c;
      e.vid_end = vend && (i == n - 1);
      e.isl_end = iend && (i == n - 1);
      plan.push_back(e);
    end
  endtask

  task automatic push_pkt();
    ent_t e;
    for (int i = 0; i < 32; i++) begin
      e = '0;
      e.mode = 3'd3;
      e.idx = 5'(i);
      e.ps = (i == 0);
      e.last = (i == 31);
      plan.push_back(e);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_run = 0; m_pkts = 0; m_err = 0; m_invid = 0;
    e_mode = 0; e_ctl = 0; e_ps = 0; e_idx = 0;
  endtask

  task automatic model(input bit d, input int c, input bit p);
    ent_t e;
    e_ps = 0; e_idx = 0; e_ctl = 0; e_mode = 0;
    if (d) begin
      if (!m_invid) m_err = 1;
      plan.delete();
      e_mode = 1; m_run = 0; m_invid = 1;
    end else begin
      if (plan.size() == 0) begin
        if (c == LEAD_V) begin
          push_n(8, 3'd0, 4'b0001, 0, 0);
          push_n(2, 3'd2, 4'b0000, 1, 0);
        end else if (p && m_run >= MINRUN && c >= LEAD_I) begin
          m_pkts = 0;
          push_n(8, 3'd0, 4'b0101, 0, 0);
          push_n(2, 3'd4, 4'b0000, 0, 0);
          push_pkt();
        end
      end
      if (plan.size() == 0) begin
        m_invid = 0;
        if (m_run < MINRUN) m_run++;
      end else begin
        e = plan.pop_front();
        e_mode = e.mode; e_ctl = e.ctl;
        e_ps = e.ps; e_idx = e.idx;
        m_invid = e.vid_end;
        m_run = 0;
        if (e.ps) m_pkts++;
        if (e.last) begin
          if (p && m_pkts < MAXP && c >= LEAD_P) push_pkt();
          else push_n(2, 3'd4, 4'b0000, 0, 1);
        end
      end
    end
  endtask

  // ---------------- tallies of DUT output ----------------
  int t_prev, t_prei, t_gbv, t_vid, t_data, t_igb, t_ctrl, t_ps;
  int dvi_bad = 0, dvi_vid = 0;

  task automatic clr();
    t_prev = 0; t_prei = 0; t_gbv = 0; t_vid = 0;
    t_data = 0; t_igb = 0; t_ctrl = 0; t_ps = 0;
  endtask

  task automatic compare_all();
    chk("mode", int'(mode), e_mode);
    chk("ctl", int'(ctl), e_ctl);
    chk("packet_start", int'(ps), e_ps);
    chk("pixel_index", int'(idx), e_idx);
    chk("sched_error", int'(err), int'(m_err));
    chk("dvi_mode", int'(d_mode), int'(de && !reset));
    chk("dvi_ctl", int'(d_ctl), 0);
    chk("dvi_packet_start", int'(d_ps), 0);
  endtask

  task automatic step(input bit d, input int c, input bit p);
    de = d; ctv = 12'(c); pv = p;
    model(d, c, p);
    @(posedge clk_pixel);
    #1;
    compare_all();
    if (mode == 3'd0 && ctl == 4'b0001) t_prev++;
    if (mode == 3'd0 && ctl == 4'b0101) t_prei++;
    if (mode == 3'd0 && ctl == 4'b0000) t_ctrl++;
    if (mode == 3'd2) t_gbv++;
    if (mode == 3'd1) t_vid++;
    if (mode == 3'd3) t_data++;
    if (mode == 3'd4) t_igb++;
    if (ps) t_ps++;
    if (d_mode > 3'd1 || d_ctl != 4'd0 || d_ps) dvi_bad++;
    if (d_mode == 3'd1) dvi_vid++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_mode", int'(mode), 0);
    chk("rst_ctl", int'(ctl), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  task automatic gap_to_island(input string nm, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, SAT, 1);
      if (ctl == 4'b0101) break;
      n++;
    end
    chk(nm, n, exp);
  endtask

  initial begin
    model_reset();
    clr();
    #12;
    do_reset();

    // Plain video line: countdown to video, no packets.
    clr();
    for (int c = 200; c >= 1; c--) step(0, c, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 200, 0);
    chk("s1_vid_pre", t_prev, 8);
    chk("s1_vid_gb", t_gbv, 2);
    chk("s1_video", t_vid, 16);
    chk("s1_err", int'(err), 0);

    // Island admitted with exactly 56 pixels of lead.
    for (int i = 0; i < 6; i++) step(0, 200, 0);
    clr();
    for (int c = 56; c >= 1; c--) step(0, c, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    chk("s2_isl_pre", t_prei, 8);
    chk("s2_pkt_start", t_ps, 1);
    chk("s2_data", t_data, 32);
    chk("s2_isl_gb", t_igb, 4);
    chk("s2_ctrl", t_ctrl, 2);
    chk("s2_ctrl_plus_pre", t_ctrl + t_prev, 10);
    chk("s2_vid_gb", t_gbv, 2);
    chk("s2_err", int'(err), 0);

    // One pixel short of lead: no island.
    for (int i = 0; i < 6; i++) step(0, 200, 0);
    clr();
    for (int c = 55; c >= 1; c--) step(0, c, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 1);
    chk("s3_isl_pre", t_prei, 0);
    chk("s3_pkt_start", t_ps, 0);
    chk("s3_vid_pre", t_prev, 8);
    chk("s3_err", int'(err), 0);

    // Saturated lookahead: a maximal island of 18 packets.
    for (int i = 0; i < 6; i++) step(0, SAT, 0);
    clr();
    for (int i = 0; i < 8 + 2 + 18 * 32 + 2; i++) step(0, SAT, 1);
    chk("s4_pkt_start", t_ps, 18);
    chk("s4_data", t_data, 18 * 32);
    chk("s4_isl_gb", t_igb, 4);
    chk("s4_last_mode", int'(mode), 4);
    gap_to_island("s4_ctrl_gap", 4);

    // Reset during island preamble, then ctrl run restarts.
    step(0, SAT, 1);
    step(0, SAT, 1);
    do_reset();
    gap_to_island("s6_ctrl_gap", 4);

    // Video forced during data pixel 5.
    clr();
    for (int i = 0; i < 7 + 2 + 5; i++) step(0, SAT, 1);
    chk("s5_idx4", int'(idx), 4);
    step(1, 0, 1);
    chk("s5_mode", int'(mode), 1);
    chk("s5_err", int'(err), 1);
    for (int i = 0; i < 3; i++) step(0, SAT, 0);
    chk("s5_err_sticky", int'(err), 1);
    chk("s5_pkt_start", t_ps, 1);
    do_reset();
    chk("s5_err_cleared", int'(err), 0);

    chk("dvi_bad", dvi_bad, 0);
    chk("dvi_video", dvi_vid, 16 + 4 + 2 + 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
